dunc16_ctrl: RTL

Control sequencer for the 16-bit accumulator datapath (PC, MD, AC, IR, memory write path).
- Generates the one-hot T0..T3 timing ring and the FETCH/EXECUTE major-cycle flip-flop.
- Holds and decodes the instruction register.
- Issues every load, increment, enable and write strobe the datapath needs, one instruction per two major cycles (8 clocks); instructions with no execute work complete in one major cycle.

---
 rtl/dunc16_ctrl.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/dunc16_ctrl.sv
// Control sequencer for the DUNC16 accumulator datapath.
// Generates the T0..T3 ring and FETCH/EXECUTE major cycle, holds the IR and
// decodes every datapath strobe. Optional build macro DUNC16_SINGLE_STEP_EN adds
// STEP/WAITING: the sequencer parks at fetch T0 after each instruction until a
// synchronised STEP rising edge. Out of reset the first instruction runs freely.
module dunc16_ctrl #(
  parameter int unsigned DW  = 16,
  parameter int unsigned AW  = 12,
  parameter int unsigned OPW = 4
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic [DW-1:0] MD_IN,
  input  logic          AC_ZERO,
`ifdef DUNC16_SINGLE_STEP_EN
  input  logic          STEP,
  output logic          WAITING,
`endif
  output logic [3:0]    T,
  output logic          FETCH,
  output logic          EXECUTE,
  output logic          HALTED,
  output logic          ADDR_SEL,
  output logic [AW-1:0] IR_ADDR,
  output logic          EN_MD,
  output logic          LD_IR,
  output logic          INC_PC,
  output logic          LD_PC,
  output logic          LD_AC,
  output logic [1:0]    ALU_OP,
  output logic          SETWRITE,
  output logic          CLRWRITE,
  output logic          WRITE,
  output logic          DO_WRITE,
  output logic          I_LDA,
  output logic          I_STA
);

  localparam logic [OPW-1:0] OpLda = OPW'(4'h0);
  localparam logic [OPW-1:0] OpSta = OPW'(4'h1);
  localparam logic [OPW-1:0] OpAdd = OPW'(4'h2);
  localparam logic [OPW-1:0] OpAnd = OPW'(4'h3);
  localparam logic [OPW-1:0] OpJmp = OPW'(4'h4);
  localparam logic [OPW-1:0] OpJz  = OPW'(4'h5);
  localparam logic [OPW-1:0] OpHlt = OPW'(4'hF);

  typedef enum logic {StFetch = 1'b0, StExec = 1'b1} cycle_e;

  cycle_e        cyc_q, cyc_d;
  logic [3:0]    t_q, t_d;
  logic          halted_q, halted_d;
  logic          write_q, write_d;
  logic [DW-1:0] ir_q, ir_d;

  logic [OPW-1:0] opcode;
  logic is_lda, is_sta, is_add, is_and, is_jmp, is_jz, is_hlt, has_exec;
  logic run;   // ring advances this clock
  logic done;  // instruction completes at this edge, returning to fetch

  assign opcode   = ir_q[DW-1 -: OPW];
  assign is_lda   = (opcode == OpLda);
  assign is_sta   = (opcode == OpSta);
  assign is_add   = (opcode == OpAdd);
  assign is_and   = (opcode == OpAnd);
  assign is_jmp   = (opcode == OpJmp);
  assign is_jz    = (opcode == OpJz);
  assign is_hlt   = (opcode == OpHlt);
  assign has_exec = is_lda | is_sta | is_add | is_and | is_jmp | is_jz;

  // Sequencer state registers.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      t_q      <= 4'b0001;
      cyc_q    <= StFetch;
      halted_q <= 1'b0;
      write_q  <= 1'b0;
      ir_q     <= '0;
    end else begin
      t_q      <= t_d;
      cyc_q    <= cyc_d;
      halted_q <= halted_d;
      write_q  <= write_d;
      ir_q     <= ir_d;
    end
  end

  // Next-state and strobe decode from (T, major cycle, IR).
  always_comb begin
    t_d      = t_q;
    cyc_d    = cyc_q;
    halted_d = halted_q;
    write_d  = write_q;
    ir_d     = ir_q;
    done     = 1'b0;
    EN_MD    = 1'b0;
    LD_IR    = 1'b0;
    INC_PC   = 1'b0;
    LD_PC    = 1'b0;
    LD_AC    = 1'b0;
    ALU_OP   = 2'b00;
    SETWRITE = 1'b0;
    CLRWRITE = 1'b0;
    DO_WRITE = 1'b0;
    if (run) begin
      t_d = {t_q[2:0], t_q[3]};
      unique case (cyc_q)
        StFetch: begin
          if (t_q[1]) EN_MD = 1'b1;
          if (t_q[2]) begin
            LD_IR  = 1'b1;
            INC_PC = 1'b1;
            ir_d   = MD_IN;
          end
          if (t_q[3]) begin
            if (has_exec)    cyc_d    = StExec;
            else if (is_hlt) halted_d = 1'b1;
            else             done     = 1'b1;
          end
        end
        StExec: begin
          if (is_lda || is_add || is_and) begin
            if (t_q[1]) EN_MD = 1'b1;
            if (t_q[2]) begin
              LD_AC  = 1'b1;
              ALU_OP = is_add ? 2'b01 : (is_and ? 2'b10 : 2'b00);
            end
          end
          if (is_sta) begin
            if (t_q[0]) begin
              SETWRITE = 1'b1;
              write_d  = 1'b1;
            end
            if (t_q[1]) DO_WRITE = 1'b1;
            if (t_q[2]) begin
              CLRWRITE = 1'b1;
              write_d  = 1'b0;
            end
          end
          if (t_q[2] && (is_jmp || (is_jz && AC_ZERO))) LD_PC = 1'b1;
          if (t_q[3]) begin
            cyc_d = StFetch;
            done  = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef DUNC16_SINGLE_STEP_EN
  logic step_meta_q, step_sync_q, step_prev_q;
  logic waiting_q, waiting_d;

  // Two-flop STEP synchroniser plus a delayed copy for rising-edge detection.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      step_meta_q <= 1'b0;
      step_sync_q <= 1'b0;
      step_prev_q <= 1'b0;
      waiting_q   <= 1'b0;
    end else begin
      step_meta_q <= STEP;
      step_sync_q <= step_meta_q;
      step_prev_q <= step_sync_q;
      waiting_q   <= waiting_d;
    end
  end

  // Park after each instruction; only a fresh STEP edge seen while parked releases it.
  always_comb begin
    waiting_d = waiting_q;
    if (done) waiting_d = 1'b1;
    else if (waiting_q && step_sync_q && !step_prev_q) waiting_d = 1'b0;
  end

  assign run     = ~halted_q & ~waiting_q;
  assign WAITING = waiting_q;
`else
  logic unused_done;
  assign unused_done = done;
  assign run         = ~halted_q;
`endif

  assign T        = t_q;
  assign FETCH    = (cyc_q == StFetch);
  assign EXECUTE  = (cyc_q == StExec);
  assign HALTED   = halted_q;
  assign WRITE    = write_q;
  assign ADDR_SEL = (cyc_q == StExec);
  assign IR_ADDR  = ir_q[AW-1:0];
  assign I_LDA    = is_lda;
  assign I_STA    = is_sta;

endmodule
